// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// ALU operation codes, FSM states and an instruction classifier.
package mc_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SLLV = 4'd10;
  localparam logic [3:0] ALU_SRLV = 4'd11;
  localparam logic [3:0] ALU_LUI  = 4'd12;

  typedef enum logic [3:0] {
    IC_ILLEGAL, IC_RTYPE, IC_IARITH, IC_LUI, IC_LW, IC_SW,
    IC_BEQ, IC_BNE, IC_J, IC_JAL, IC_JR
  } iclass_t;

  function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] funct);
    iclass_t c;
    c = IC_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_SLTU,
          F_SLL, F_SRL, F_SLLV, F_SRLV: c = IC_RTYPE;
          F_JR:                         c = IC_JR;
          default:                      c = IC_ILLEGAL;
        endcase
      end
      OP_J:                               c = IC_J;
      OP_JAL:                             c = IC_JAL;
      OP_BEQ:                             c = IC_BEQ;
      OP_BNE:                             c = IC_BNE;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  c = IC_IARITH;
      OP_LUI:                             c = IC_LUI;
      OP_LW:                              c = IC_LW;
      OP_SW:                              c = IC_SW;
      default:                            c = IC_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational Op/Funct decode to the EXE-stage ALU operation and the
// shamt operand select for immediate shifts.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       shift_sel
);

  always_comb begin
    alu_op    = ALU_NOP;
    shift_sel = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD:  alu_op = ALU_ADD;
          F_SUB:  alu_op = ALU_SUB;
          F_AND:  alu_op = ALU_AND;
          F_OR:   alu_op = ALU_OR;
          F_NOR:  alu_op = ALU_NOR;
          F_SLT:  alu_op = ALU_SLT;
          F_SLTU: alu_op = ALU_SLTU;
          F_SLLV: alu_op = ALU_SLLV;
          F_SRLV: alu_op = ALU_SRLV;
          F_SLL: begin
            alu_op    = ALU_SLL;
            shift_sel = 1'b1;
          end
          F_SRL: begin
            alu_op    = ALU_SRL;
            shift_sel = 1'b1;
          end
          default: alu_op = ALU_NOP;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_op = ALU_ADD;
      OP_SLTI:               alu_op = ALU_SLT;
      OP_ANDI:               alu_op = ALU_AND;
      OP_ORI:                alu_op = ALU_OR;
      OP_LUI:                alu_op = ALU_LUI;
      OP_BEQ, OP_BNE:        alu_op = ALU_SUB;
      default:               alu_op = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXE/MEM/WB sequencing with
// Moore outputs decoded from the current state and the latched Op/Funct.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ST_W = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [5:0]      Op,
  input  logic [5:0]      Funct,
  input  logic            Zero,
  output logic            PCWrite,
  output logic            IRWrite,
  output logic            IorD,
  output logic            MemWrite,
  output logic            RegWrite,
  output logic [1:0]      RegDst,
  output logic [1:0]      WDSel,
  output logic            EXTOp,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [3:0]      ALUOp,
  output logic [1:0]      PCSource,
  output logic            instr_done,
  output logic            illegal,
  output logic [ST_W-1:0] state
);

  state_t     state_q;
  iclass_t    iclass;
  logic [3:0] dec_alu_op;
  logic       dec_shift;

  assign iclass = classify(Op, Funct);
  assign state  = ST_W'(state_q);

  mc_alu_dec u_alu_dec (
    .op        (Op),
    .funct     (Funct),
    .alu_op    (dec_alu_op),
    .shift_sel (dec_shift)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: state_q <= (iclass inside {IC_J, IC_JAL, IC_JR, IC_ILLEGAL}) ? S_FETCH : S_EXE;
        S_EXE: begin
          if (iclass inside {IC_BEQ, IC_BNE})    state_q <= S_FETCH;
          else if (iclass inside {IC_LW, IC_SW}) state_q <= S_MEM;
          else                                   state_q <= S_WB;
        end
        S_MEM:    state_q <= (iclass == IC_LW) ? S_WB : S_FETCH;
        S_WB:     state_q <= S_FETCH;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 2'd0;
    WDSel      = 2'd0;
    EXTOp      = 1'b0;
    ALUSrcA    = 2'd0;
    ALUSrcB    = 2'd0;
    ALUOp      = ALU_NOP;
    PCSource   = 2'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        ALUSrcB = 2'd1;
        ALUOp   = ALU_ADD;
        PCWrite = 1'b1;
      end
      S_DECODE: begin
        // Branch target PC+4+(imm<<2) is computed here and parked in ALUOut.
        ALUSrcB = 2'd3;
        EXTOp   = 1'b1;
        ALUOp   = ALU_ADD;
        case (iclass)
          IC_J: begin
            PCSource = 2'd2; PCWrite = 1'b1; instr_done = 1'b1;
          end
          IC_JAL: begin
            PCSource = 2'd2; PCWrite = 1'b1; instr_done = 1'b1;
            RegWrite = 1'b1; RegDst = 2'd2; WDSel = 2'd2;
          end
          IC_JR: begin
            PCSource = 2'd3; PCWrite = 1'b1; instr_done = 1'b1;
          end
          IC_ILLEGAL: begin
            illegal = 1'b1; instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXE: begin
        ALUOp = dec_alu_op;
        case (iclass)
          IC_RTYPE:  ALUSrcA = dec_shift ? 2'd2 : 2'd1;
          IC_IARITH: begin
            ALUSrcA = 2'd1; ALUSrcB = 2'd2;
            EXTOp   = (Op == OP_ADDI) || (Op == OP_SLTI);
          end
          IC_LUI:    ALUSrcB = 2'd2;
          IC_LW, IC_SW: begin
            ALUSrcA = 2'd1; ALUSrcB = 2'd2; EXTOp = 1'b1;
          end
          IC_BEQ, IC_BNE: begin
            ALUSrcA    = 2'd1;
            PCSource   = 2'd1;
            PCWrite    = (iclass == IC_BEQ) ? Zero : ~Zero;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        IorD = 1'b1;
        if (iclass == IC_SW) begin
          MemWrite   = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        RegDst     = (iclass == IC_RTYPE) ? 2'd1 : 2'd0;
        WDSel      = (iclass == IC_LW) ? 2'd1 : 2'd0;
      end
      default: ;
    endcase
    // Held reset overrides everything, so no partial write escapes an abort.
    if (!rstn) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 2'd0;
      WDSel      = 2'd0;
      EXTOp      = 1'b0;
      ALUSrcA    = 2'd0;
      ALUSrcB    = 2'd0;
      ALUOp      = ALU_NOP;
      PCSource   = 2'd0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: each instruction pushes its hand-written
// per-cycle control vectors; a negedge monitor pops and compares.
module tb_mc_ctrl;

  localparam int W = 25;

  localparam logic [3:0] A_NOP  = 4'd0;
  localparam logic [3:0] A_ADD  = 4'd1;
  localparam logic [3:0] A_SUB  = 4'd2;
  localparam logic [3:0] A_AND  = 4'd3;
  localparam logic [3:0] A_OR   = 4'd4;
  localparam logic [3:0] A_NOR  = 4'd5;
  localparam logic [3:0] A_SLT  = 4'd6;
  localparam logic [3:0] A_SLTU = 4'd7;
  localparam logic [3:0] A_SLL  = 4'd8;
  localparam logic [3:0] A_SRL  = 4'd9;
  localparam logic [3:0] A_SRLV = 4'd11;
  localparam logic [3:0] A_LUI  = 4'd12;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       PCWrite, IRWrite, IorD, MemWrite, RegWrite, EXTOp, instr_done, illegal;
  logic [1:0] RegDst, WDSel, ALUSrcA, ALUSrcB, PCSource;
  logic [3:0] ALUOp;
  logic [2:0] state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         mon_en = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [W-1:0] act;

  mc_ctrl #(.ST_W(3)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .WDSel(WDSel), .EXTOp(EXTOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  assign act = {state, PCWrite, IRWrite, IorD, MemWrite, RegWrite, RegDst, WDSel,
                EXTOp, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal};

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ev(
    input logic [2:0] st, input logic pcw, input logic irw, input logic iord,
    input logic memw, input logic regw, input logic [1:0] rdst, input logic [1:0] wds,
    input logic ext, input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] aop,
    input logic [1:0] pcs, input logic done, input logic ill);
    return {st, pcw, irw, iord, memw, regw, rdst, wds, ext, sa, sb, aop, pcs, done, ill};
  endfunction

  logic [W-1:0] v_fetch, v_decode, v_reset;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL underflow cyc=%0d got=%h expected=<none>", cyc, act);
      end else begin
        check(name_q.pop_front(), act, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic push(input string name, input logic [W-1:0] v);
    exp_q.push_back(v);
    name_q.push_back(name);
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] funct, input logic z, input int n);
    Op = op; Funct = funct; Zero = z;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic r_type(input string nm, input logic [5:0] funct, input logic [3:0] aop,
                        input logic [1:0] sa);
    push({nm, "_fetch"}, v_fetch);
    push({nm, "_decode"}, v_decode);
    push({nm, "_exe"}, ev(3'd2, 0,0,0,0,0, 2'd0, 2'd0, 0, sa, 2'd0, aop, 2'd0, 0, 0));
    push({nm, "_wb"}, ev(3'd4, 0,0,0,0,1, 2'd1, 2'd0, 0, 2'd0, 2'd0, A_NOP, 2'd0, 1, 0));
    run(6'b000000, funct, 1'($urandom_range(0, 1)), 4);
  endtask

  task automatic i_arith(input string nm, input logic [5:0] op, input logic [3:0] aop,
                         input logic ext, input logic [1:0] sa);
    push({nm, "_fetch"}, v_fetch);
    push({nm, "_decode"}, v_decode);
    push({nm, "_exe"}, ev(3'd2, 0,0,0,0,0, 2'd0, 2'd0, ext, sa, 2'd2, aop, 2'd0, 0, 0));
    push({nm, "_wb"}, ev(3'd4, 0,0,0,0,1, 2'd0, 2'd0, 0, 2'd0, 2'd0, A_NOP, 2'd0, 1, 0));
    run(op, 6'b000000, 1'($urandom_range(0, 1)), 4);
  endtask

  task automatic branch(input string nm, input logic [5:0] op, input logic z, input logic pcw);
    push({nm, "_fetch"}, v_fetch);
    push({nm, "_decode"}, v_decode);
    push({nm, "_exe"}, ev(3'd2, pcw,0,0,0,0, 2'd0, 2'd0, 0, 2'd1, 2'd0, A_SUB, 2'd1, 1, 0));
    run(op, 6'b000000, z, 3);
  endtask

  // decode-only instructions: jumps and illegal encodings
  task automatic two_cyc(input string nm, input logic [5:0] op, input logic [5:0] funct,
                         input logic [W-1:0] dec);
    push({nm, "_fetch"}, v_fetch);
    push({nm, "_decode"}, dec);
    run(op, funct, 1'($urandom_range(0, 1)), 2);
  endtask

  initial begin
    v_fetch  = ev(3'd0, 1,1,0,0,0, 2'd0, 2'd0, 0, 2'd0, 2'd1, A_ADD, 2'd0, 0, 0);
    v_decode = ev(3'd1, 0,0,0,0,0, 2'd0, 2'd0, 1, 2'd0, 2'd3, A_ADD, 2'd0, 0, 0);
    v_reset  = '0;
    rstn = 1'b0; Op = 6'b000000; Funct = 6'b100000; Zero = 1'b0;

    #3;
    check("reset_hold", act, v_reset);
    @(posedge clk); #1;
    check("reset_hold2", act, v_reset);
    rstn = 1'b1;
    mon_en = 1'b1;

    r_type("add", 6'b100000, A_ADD, 2'd1);
    r_type("sub", 6'b100010, A_SUB, 2'd1);
    r_type("and", 6'b100100, A_AND, 2'd1);
    r_type("nor", 6'b100111, A_NOR, 2'd1);
    r_type("sltu", 6'b101011, A_SLTU, 2'd1);
    r_type("srlv", 6'b000110, A_SRLV, 2'd1);
    r_type("sll", 6'b000000, A_SLL, 2'd2);
    r_type("srl", 6'b000010, A_SRL, 2'd2);

    i_arith("addi", 6'b001000, A_ADD, 1'b1, 2'd1);
    i_arith("slti", 6'b001010, A_SLT, 1'b1, 2'd1);
    i_arith("ori", 6'b001101, A_OR, 1'b0, 2'd1);
    i_arith("lui", 6'b001111, A_LUI, 1'b0, 2'd0);

    // lw: five cycles, MDR path in WB
    push("lw_fetch", v_fetch);
    push("lw_decode", v_decode);
    push("lw_exe", ev(3'd2, 0,0,0,0,0, 2'd0, 2'd0, 1, 2'd1, 2'd2, A_ADD, 2'd0, 0, 0));
    push("lw_mem", ev(3'd3, 0,0,1,0,0, 2'd0, 2'd0, 0, 2'd0, 2'd0, A_NOP, 2'd0, 0, 0));
    push("lw_wb", ev(3'd4, 0,0,0,0,1, 2'd0, 2'd1, 0, 2'd0, 2'd0, A_NOP, 2'd0, 1, 0));
    run(6'b100011, 6'b000000, 1'b1, 5);

    // sw: four cycles, store only in MEM
    push("sw_fetch", v_fetch);
    push("sw_decode", v_decode);
    push("sw_exe", ev(3'd2, 0,0,0,0,0, 2'd0, 2'd0, 1, 2'd1, 2'd2, A_ADD, 2'd0, 0, 0));
    push("sw_mem", ev(3'd3, 0,0,1,1,0, 2'd0, 2'd0, 0, 2'd0, 2'd0, A_NOP, 2'd0, 1, 0));
    run(6'b101011, 6'b000000, 1'b0, 4);

    branch("beq_taken", 6'b000100, 1'b1, 1'b1);
    branch("beq_not", 6'b000100, 1'b0, 1'b0);
    branch("bne_taken", 6'b000101, 1'b0, 1'b1);
    branch("bne_not", 6'b000101, 1'b1, 1'b0);

    two_cyc("j", 6'b000010, 6'b000000,
            ev(3'd1, 1,0,0,0,0, 2'd0, 2'd0, 1, 2'd0, 2'd3, A_ADD, 2'd2, 1, 0));
    two_cyc("jal", 6'b000011, 6'b000000,
            ev(3'd1, 1,0,0,0,1, 2'd2, 2'd2, 1, 2'd0, 2'd3, A_ADD, 2'd2, 1, 0));
    two_cyc("jr", 6'b000000, 6'b001000,
            ev(3'd1, 1,0,0,0,0, 2'd0, 2'd0, 1, 2'd0, 2'd3, A_ADD, 2'd3, 1, 0));
    two_cyc("ill_op", 6'b111111, 6'b000000,
            ev(3'd1, 0,0,0,0,0, 2'd0, 2'd0, 1, 2'd0, 2'd3, A_ADD, 2'd0, 1, 1));
    two_cyc("ill_funct", 6'b000000, 6'b000001,
            ev(3'd1, 0,0,0,0,0, 2'd0, 2'd0, 1, 2'd0, 2'd3, A_ADD, 2'd0, 1, 1));

    // instruction after an illegal one starts cleanly
    r_type("or", 6'b100101, A_OR, 2'd1);

    mon_en = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got=%0d entries expected=0", exp_q.size());
    end

    // asynchronous abort in the middle of EXE
    Op = 6'b000000; Funct = 6'b100000; Zero = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_pre_exe", act, ev(3'd2, 0,0,0,0,0, 2'd0, 2'd0, 0, 2'd1, 2'd0, A_ADD, 2'd0, 0, 0));
    #1 rstn = 1'b0;
    #1;
    check("abort_async", act, v_reset);
    @(posedge clk); #1;
    check("abort_held", act, v_reset);
    rstn = 1'b1;
    #1;
    check("abort_release", act, v_fetch);
    @(posedge clk); #1;
    check("abort_decode", act, v_decode);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
